// File: rtl/mem_wb_stage.sv
// Memory-to-writeback pipeline register: formats load data, selects the
// register-file write value, raises held misalignment traps, counts retirements.
module mem_wb_stage #(
  parameter int XLEN      = 32,
  parameter int INSTRET_W = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic                 i_stall,
  input  logic                 i_flush,
  input  logic [31:0]          i_inst,
  input  logic [XLEN-1:0]      i_alu_res,
  input  logic [XLEN-1:0]      i_mem_word,
  input  logic [XLEN-1:0]      i_pc,
  input  logic [XLEN-1:0]      i_pc_next,
  input  logic                 i_reg_write,
  input  logic [1:0]           i_wb_sel,
  input  logic [XLEN-1:0]      i_csr_rdata,
  input  logic                 i_ex_ld,
  input  logic                 i_ex_st,
  input  logic                 i_trap_ack,
  output logic                 o_rf_we,
  output logic [4:0]           o_rf_waddr,
  output logic [XLEN-1:0]      o_rf_wdata,
  output logic                 o_wb_valid,
  output logic [XLEN-1:0]      o_wb_pc,
  output logic [XLEN-1:0]      o_wb_pc_next,
  output logic                 o_trap_req,
  output logic [3:0]           o_trap_cause,
  output logic [XLEN-1:0]      o_trap_tval,
  output logic [XLEN-1:0]      o_trap_epc,
  output logic                 o_hold,
  output logic [INSTRET_W-1:0] o_instret
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } state_t;

  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;

  function automatic logic [XLEN-1:0] fmt_load(
    input logic [XLEN-1:0] word,
    input logic [1:0]      off,
    input logic [2:0]      f3
  );
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic [XLEN-1:0]    res;
    b_s = $signed(word[{off, 3'b000} +: 8]);
    h_s = $signed(off[1] ? word[31:16] : word[15:0]);
    case (f3)
      3'b000:  res = {{(XLEN-8){b_s[7]}}, b_s};
      3'b100:  res = {{(XLEN-8){1'b0}}, b_s};
      3'b001:  res = {{(XLEN-16){h_s[15]}}, h_s};
      3'b101:  res = {{(XLEN-16){1'b0}}, h_s};
      default: res = word;
    endcase
    return res;
  endfunction

  state_t                 state_p1;
  logic                   vld_p1;
  logic                   rf_we_p1;
  logic [4:0]             rf_waddr_p1;
  logic [XLEN-1:0]        rf_wdata_p1;
  logic [XLEN-1:0]        pc_p1;
  logic [XLEN-1:0]        pc_next_p1;
  logic                   trap_req_p1;
  logic                   hold_p1;
  logic [3:0]             trap_cause_p1;
  logic [XLEN-1:0]        trap_tval_p1;
  logic [XLEN-1:0]        trap_epc_p1;
  logic [INSTRET_W-1:0]   instret_p1;

  // Stage p0: qualify the instruction sitting in MEM and build its write value
  logic                   cap_p0;
  logic                   exc_p0;
  logic [4:0]             rd_p0;
  logic                   we_p0;
  logic [3:0]             cause_p0;
  logic [XLEN-1:0]        wdata_p0;
  logic                   unused_inst_bits;

  assign cap_p0   = (state_p1 == ST_RUN) & i_valid & ~i_stall & ~i_flush;
  assign exc_p0   = i_ex_ld | i_ex_st;
  assign rd_p0    = i_inst[11:7];
  assign we_p0    = i_reg_write & (rd_p0 != 5'd0);
  assign cause_p0 = i_ex_ld ? CAUSE_LD_MISALIGN : CAUSE_ST_MISALIGN;
  assign unused_inst_bits = ^{i_inst[31:15], i_inst[6:0]};

  always_comb begin
    wdata_p0 = i_alu_res;
    case (i_wb_sel)
      2'b00:   wdata_p0 = i_alu_res;
      2'b01:   wdata_p0 = fmt_load(i_mem_word, i_alu_res[1:0], i_inst[14:12]);
      2'b10:   wdata_p0 = i_pc + XLEN'(4);
      default: wdata_p0 = i_csr_rdata;
    endcase
  end

  // Stage p1: writeback register, trap latch and retirement counter
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_p1      <= ST_RUN;
      vld_p1        <= 1'b0;
      rf_we_p1      <= 1'b0;
      rf_waddr_p1   <= '0;
      rf_wdata_p1   <= '0;
      pc_p1         <= '0;
      pc_next_p1    <= '0;
      trap_req_p1   <= 1'b0;
      hold_p1       <= 1'b0;
      trap_cause_p1 <= '0;
      trap_tval_p1  <= '0;
      trap_epc_p1   <= '0;
      instret_p1    <= '0;
    end else begin
      vld_p1   <= 1'b0;
      rf_we_p1 <= 1'b0;
      case (state_p1)
        ST_RUN: begin
          if (cap_p0) begin
            if (exc_p0) begin
              state_p1      <= ST_TRAP;
              trap_req_p1   <= 1'b1;
              hold_p1       <= 1'b1;
              trap_cause_p1 <= cause_p0;
              trap_tval_p1  <= i_alu_res;
              trap_epc_p1   <= i_pc;
            end else begin
              vld_p1      <= 1'b1;
              rf_we_p1    <= we_p0;
              rf_waddr_p1 <= rd_p0;
              rf_wdata_p1 <= wdata_p0;
              pc_p1       <= i_pc;
              pc_next_p1  <= i_pc_next;
              instret_p1  <= instret_p1 + INSTRET_W'(1);
            end
          end
        end
        ST_TRAP: begin
          if (i_trap_ack) begin
            state_p1    <= ST_RUN;
            trap_req_p1 <= 1'b0;
            hold_p1     <= 1'b0;
          end
        end
        default: state_p1 <= ST_RUN;
      endcase
    end
  end

  assign o_rf_we      = rf_we_p1;
  assign o_rf_waddr   = rf_waddr_p1;
  assign o_rf_wdata   = rf_wdata_p1;
  assign o_wb_valid   = vld_p1;
  assign o_wb_pc      = pc_p1;
  assign o_wb_pc_next = pc_next_p1;
  assign o_trap_req   = trap_req_p1;
  assign o_trap_cause = trap_cause_p1;
  assign o_trap_tval  = trap_tval_p1;
  assign o_trap_epc   = trap_epc_p1;
  assign o_hold       = hold_p1;
  assign o_instret    = instret_p1;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed and randomized bench for mem_wb_stage against an arithmetic reference model.
module tb_mem_wb_stage;
  localparam int XLEN = 32;
  localparam int IW   = 6;
  localparam int IMOD = 1 << IW;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic            i_valid, i_stall, i_flush;
  logic [31:0]     i_inst;
  logic [XLEN-1:0] i_alu_res, i_mem_word, i_pc, i_pc_next, i_csr_rdata;
  logic            i_reg_write;
  logic [1:0]      i_wb_sel;
  logic            i_ex_ld, i_ex_st, i_trap_ack;
  logic            o_rf_we, o_wb_valid, o_trap_req, o_hold;
  logic [4:0]      o_rf_waddr;
  logic [XLEN-1:0] o_rf_wdata, o_wb_pc, o_wb_pc_next, o_trap_tval, o_trap_epc;
  logic [3:0]      o_trap_cause;
  logic [IW-1:0]   o_instret;

  always #5 i_clk = ~i_clk;

  mem_wb_stage #(.XLEN(XLEN), .INSTRET_W(IW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_stall(i_stall), .i_flush(i_flush),
    .i_inst(i_inst), .i_alu_res(i_alu_res), .i_mem_word(i_mem_word), .i_pc(i_pc),
    .i_pc_next(i_pc_next), .i_reg_write(i_reg_write), .i_wb_sel(i_wb_sel),
    .i_csr_rdata(i_csr_rdata), .i_ex_ld(i_ex_ld), .i_ex_st(i_ex_st), .i_trap_ack(i_trap_ack),
    .o_rf_we(o_rf_we), .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata),
    .o_wb_valid(o_wb_valid), .o_wb_pc(o_wb_pc), .o_wb_pc_next(o_wb_pc_next),
    .o_trap_req(o_trap_req), .o_trap_cause(o_trap_cause), .o_trap_tval(o_trap_tval),
    .o_trap_epc(o_trap_epc), .o_hold(o_hold), .o_instret(o_instret)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit          m_trap;
  bit          m_wbv, m_we;
  int unsigned m_waddr, m_wdata, m_pc, m_pcn, m_cause, m_tval, m_epc, m_instret;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned ref_load(input int unsigned word, input int unsigned off,
                                           input int unsigned f3);
    int unsigned b, h;
    b = (word >> (off * 8)) & 32'hFF;
    h = (word >> ((off / 2) * 16)) & 32'hFFFF;
    case (f3)
      0:       return (b >= 128) ? (b | 32'hFFFFFF00) : b;
      4:       return b;
      1:       return (h >= 32768) ? (h | 32'hFFFF0000) : h;
      5:       return h;
      default: return word;
    endcase
  endfunction

  task automatic model_reset();
    m_trap = 0; m_wbv = 0; m_we = 0;
    m_waddr = 0; m_wdata = 0; m_pc = 0; m_pcn = 0;
    m_cause = 0; m_tval = 0; m_epc = 0; m_instret = 0;
  endtask

  task automatic model_step();
    int unsigned rd;
    rd = (i_inst >> 7) & 31;
    m_wbv = 0;
    m_we  = 0;
    if (m_trap) begin
      if (i_trap_ack) m_trap = 0;
    end else if (i_valid && !i_stall && !i_flush) begin
      if (i_ex_ld || i_ex_st) begin
        m_trap  = 1;
        m_cause = i_ex_ld ? 4 : 6;
        m_tval  = i_alu_res;
        m_epc   = i_pc;
      end else begin
        m_wbv   = 1;
        m_we    = i_reg_write && (rd != 0);
        m_waddr = rd;
        case (i_wb_sel)
          2'd0: m_wdata = i_alu_res;
          2'd1: m_wdata = ref_load(i_mem_word, i_alu_res % 4, (i_inst >> 12) & 7);
          2'd2: m_wdata = i_pc + 4;
          default: m_wdata = i_csr_rdata;
        endcase
        m_pc      = i_pc;
        m_pcn     = i_pc_next;
        m_instret = (m_instret + 1) % IMOD;
      end
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".wb_valid"}, 64'(o_wb_valid), 64'(m_wbv));
    check({tag, ".rf_we"},    64'(o_rf_we),    64'(m_we));
    check({tag, ".trap_req"}, 64'(o_trap_req), 64'(m_trap));
    check({tag, ".hold"},     64'(o_hold),     64'(m_trap));
    check({tag, ".instret"},  64'(o_instret),  64'(m_instret));
    if (m_wbv) begin
      check({tag, ".waddr"},   64'(o_rf_waddr),   64'(m_waddr));
      check({tag, ".wdata"},   64'(o_rf_wdata),   64'(m_wdata));
      check({tag, ".pc"},      64'(o_wb_pc),      64'(m_pc));
      check({tag, ".pc_next"}, 64'(o_wb_pc_next), 64'(m_pcn));
    end
    if (m_trap) begin
      check({tag, ".cause"}, 64'(o_trap_cause), 64'(m_cause));
      check({tag, ".tval"},  64'(o_trap_tval),  64'(m_tval));
      check({tag, ".epc"},   64'(o_trap_epc),   64'(m_epc));
    end
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge i_clk);
    #1;
    compare_model(tag);
  endtask

  task automatic set_idle();
    i_valid = 0; i_stall = 0; i_flush = 0; i_ex_ld = 0; i_ex_st = 0; i_trap_ack = 0;
    i_reg_write = 0; i_wb_sel = 2'd0; i_inst = 32'h13;
  endtask

  task automatic set_instr(input logic [2:0] f3, input logic [4:0] rd, input logic [1:0] sel,
                           input logic [31:0] alu, input logic [31:0] word, input logic [31:0] pc);
    set_idle();
    i_valid = 1; i_reg_write = 1; i_wb_sel = sel;
    i_inst = {17'h0, f3, rd, 7'h03};
    i_alu_res = alu; i_mem_word = word; i_pc = pc; i_pc_next = pc + 32'd4;
    i_csr_rdata = 32'hC5C5_0001;
  endtask

  task automatic randomize_inputs(input bit allow_ack);
    i_valid     = ($urandom_range(0, 3) != 0);
    i_stall     = ($urandom_range(0, 4) == 0);
    i_flush     = ($urandom_range(0, 5) == 0);
    i_inst      = $urandom;
    i_alu_res   = $urandom;
    i_mem_word  = $urandom;
    i_pc        = $urandom;
    i_pc_next   = $urandom;
    i_csr_rdata = $urandom;
    i_reg_write = 1'($urandom_range(0, 1));
    i_wb_sel    = 2'($urandom_range(0, 3));
    i_ex_ld     = ($urandom_range(0, 9) == 0);
    i_ex_st     = ($urandom_range(0, 9) == 0);
    i_trap_ack  = allow_ack && ($urandom_range(0, 2) == 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".rf_we"},    64'(o_rf_we),      64'(0));
    check({tag, ".waddr"},    64'(o_rf_waddr),   64'(0));
    check({tag, ".wdata"},    64'(o_rf_wdata),   64'(0));
    check({tag, ".wb_valid"}, 64'(o_wb_valid),   64'(0));
    check({tag, ".pc"},       64'(o_wb_pc),      64'(0));
    check({tag, ".pc_next"},  64'(o_wb_pc_next), 64'(0));
    check({tag, ".trap_req"}, 64'(o_trap_req),   64'(0));
    check({tag, ".cause"},    64'(o_trap_cause), 64'(0));
    check({tag, ".tval"},     64'(o_trap_tval),  64'(0));
    check({tag, ".epc"},      64'(o_trap_epc),   64'(0));
    check({tag, ".hold"},     64'(o_hold),       64'(0));
    check({tag, ".instret"},  64'(o_instret),    64'(0));
  endtask

  task automatic async_reset(input string tag);
    #2;
    i_rst = 0;
    #1;
    check_all_zero(tag);
    model_reset();
    @(posedge i_clk);
    #1;
    i_rst = 1;
  endtask

  initial begin
    set_idle();
    i_alu_res = 0; i_mem_word = 0; i_pc = 0; i_pc_next = 0; i_csr_rdata = 0;
    i_rst = 0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    check_all_zero("por");
    i_rst = 1;

    // Some traffic, then reset in the middle of it
    for (int i = 0; i < 4; i++) begin
      set_instr(3'b010, 5'd3, 2'd0, 32'h1000 + i, 32'h0, 32'h80 + 4 * i);
      step("pre_rst");
    end
    async_reset("mid_rst");

    // LW after reset
    set_instr(3'b010, 5'd5, 2'd1, 32'h100, 32'h8899AABB, 32'h10);
    step("lw");
    check("lw.we_const",    64'(o_rf_we),    64'(1));
    check("lw.waddr_const", 64'(o_rf_waddr), 64'(5));
    check("lw.wdata_const", 64'(o_rf_wdata), 64'(32'h8899AABB));
    check("lw.instret_1",   64'(o_instret),  64'(1));

    // Byte/halfword formatting
    set_instr(3'b000, 5'd6, 2'd1, 32'h101, 32'h8899AABB, 32'h14); step("lb");
    check("lb.const", 64'(o_rf_wdata), 64'(32'hFFFFFFAA));
    set_instr(3'b100, 5'd7, 2'd1, 32'h103, 32'h8899AABB, 32'h18); step("lbu");
    check("lbu.const", 64'(o_rf_wdata), 64'(32'h00000088));
    set_instr(3'b001, 5'd8, 2'd1, 32'h102, 32'h8899AABB, 32'h1C); step("lh");
    check("lh.const", 64'(o_rf_wdata), 64'(32'hFFFF8899));
    set_instr(3'b101, 5'd9, 2'd1, 32'h100, 32'h8899AABB, 32'h20); step("lhu");
    check("lhu.const", 64'(o_rf_wdata), 64'(32'h0000AABB));

    // PC+4 select and x0 destination
    set_instr(3'b000, 5'd1, 2'd2, 32'h0, 32'h0, 32'h200); step("jal");
    check("jal.const", 64'(o_rf_wdata), 64'(32'h204));
    set_instr(3'b000, 5'd0, 2'd2, 32'h0, 32'h0, 32'h200); step("jal_x0");
    check("jal_x0.we", 64'(o_rf_we), 64'(0));
    check("jal_x0.vld", 64'(o_wb_valid), 64'(1));
    set_instr(3'b000, 5'd2, 2'd3, 32'h0, 32'h0, 32'h204); step("csr");

    // Stall bubbles and flush beating an exception
    set_instr(3'b010, 5'd4, 2'd0, 32'h55, 32'h0, 32'h300);
    i_stall = 1;
    for (int i = 0; i < 3; i++) step("stall");
    check("stall.instret", 64'(o_instret), 64'(8));
    i_stall = 0; i_flush = 1; i_ex_ld = 1;
    step("flush_ex");
    check("flush_ex.trap", 64'(o_trap_req), 64'(0));

    // Misaligned load trap, held while inputs toggle
    set_instr(3'b010, 5'd10, 2'd1, 32'h103, 32'h0, 32'h40);
    i_ex_ld = 1;
    step("trap_ld");
    check("trap_ld.req",   64'(o_trap_req),   64'(1));
    check("trap_ld.cause", 64'(o_trap_cause), 64'(4));
    check("trap_ld.tval",  64'(o_trap_tval),  64'(32'h103));
    check("trap_ld.epc",   64'(o_trap_epc),   64'(32'h40));
    for (int i = 0; i < 5; i++) begin
      randomize_inputs(1'b0);
      step("trap_hold");
    end
    set_idle();
    i_trap_ack = 1;
    step("trap_ack");
    check("trap_ack.req", 64'(o_trap_req), 64'(0));
    set_instr(3'b010, 5'd11, 2'd0, 32'h77, 32'h0, 32'h44);
    i_trap_ack = 1;
    step("resume");
    check("resume.vld", 64'(o_wb_valid), 64'(1));

    // Both misalignment flags: load wins
    set_instr(3'b010, 5'd12, 2'd0, 32'h202, 32'h0, 32'h48);
    i_ex_ld = 1; i_ex_st = 1;
    step("both_ex");
    check("both_ex.cause", 64'(o_trap_cause), 64'(4));
    set_idle(); i_ex_st = 1; i_trap_ack = 1;
    step("both_ack");
    set_instr(3'b010, 5'd12, 2'd0, 32'h206, 32'h0, 32'h4C);
    i_ex_st = 1;
    step("st_ex");
    check("st_ex.cause", 64'(o_trap_cause), 64'(6));

    // Reset while a trap is pending
    async_reset("rst_in_trap");

    // Counter wrap: run to all-ones, then one more retirement
    for (int i = 0; i < IMOD - 1; i++) begin
      set_instr(3'b010, 5'(1 + i % 31), 2'd0, $urandom, 32'h0, 32'h1000 + 4 * i);
      step("fill");
    end
    check("wrap.ones", 64'(o_instret), 64'(IMOD - 1));
    set_instr(3'b010, 5'd13, 2'd0, 32'h9, 32'h0, 32'h2000);
    step("wrap");
    check("wrap.zero", 64'(o_instret), 64'(0));

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      randomize_inputs(1'b1);
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end
endmodule
